// File: rtl/pl_fetch_unit_if.sv
// rtl/pl_fetch_unit_if.sv - instruction memory request/response bus
interface pl_fetch_unit_if #(
    parameter int PROG_CTR_WID = 10
);
    logic                    imem_req;
    logic [PROG_CTR_WID-1:0] imem_addr;
    logic                    imem_ready;
    logic                    imem_rvalid;
    logic [15:0]             imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/pl_fetch_unit.sv
// rtl/pl_fetch_unit.sv - instruction fetch front end with in-order buffer
module pl_fetch_unit #(
    parameter int PROG_CTR_WID = 10,
    parameter int BUF_DEPTH    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_ID,
    input  logic                    branch_taken_EX,
    input  logic [PROG_CTR_WID-1:0] branch_target_EX,
    pl_fetch_unit_if.master         imem,
    output logic [15:0]             instr_mem_out,
    output logic                    instr_valid,
    output logic [PROG_CTR_WID-1:0] instr_pc,
    output logic [PROG_CTR_WID-1:0] fetch_pc
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(BUF_DEPTH - 1);

    logic [15:0]             instr_buf [BUF_DEPTH];
    logic [PROG_CTR_WID-1:0] pc_buf    [BUF_DEPTH];
    logic [PROG_CTR_WID-1:0] tag_buf   [BUF_DEPTH];

    logic [PTR_W-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
    logic [CNT_W-1:0] count, outstanding, discard_cnt;
    logic [CNT_W:0]   in_use;
    logic             accept, rsp, drop, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    // Credits cover both buffered words and requests still in flight.
    assign in_use        = {1'b0, count} + {1'b0, outstanding};
    assign imem.imem_req  = !rst && !branch_taken_EX && (in_use < DEPTH_C);
    assign imem.imem_addr = fetch_pc;

    assign accept = imem.imem_req && imem.imem_ready;
    assign rsp    = imem.imem_rvalid && (outstanding != '0);
    assign drop   = rsp && ((discard_cnt != '0) || branch_taken_EX);
    assign push   = rsp && !drop;

    assign instr_valid   = (count != '0);
    assign pop           = instr_valid && !stall_ID && !branch_taken_EX;
    assign instr_mem_out = instr_valid ? instr_buf[rd_ptr] : 16'h0000;
    assign instr_pc      = instr_valid ? pc_buf[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            // The tag FIFO follows every response, stale or not, to stay aligned.
            if (accept) begin
                tag_buf[tag_wr] <= fetch_pc;
                tag_wr          <= ptr_inc(tag_wr);
            end
            if (rsp) begin
                tag_rd <= ptr_inc(tag_rd);
            end
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(rsp);

            if (branch_taken_EX) begin
                fetch_pc    <= branch_target_EX;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                // Everything still in flight is stale, including words already marked.
                discard_cnt <= outstanding - CNT_W'(rsp);
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 1'b1;
                end
                if (push) begin
                    instr_buf[wr_ptr] <= imem.imem_rdata;
                    pc_buf[wr_ptr]    <= tag_buf[tag_rd];
                    wr_ptr            <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
                if (drop) begin
                    discard_cnt <= discard_cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pl_fetch_unit.sv
// tb/tb_pl_fetch_unit.sv - directed vector bench for pl_fetch_unit
module tb_pl_fetch_unit;
    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall_ID;
    logic         branch_taken_EX;
    logic [W-1:0] branch_target_EX;
    logic [15:0]  instr_mem_out;
    logic         instr_valid;
    logic [W-1:0] instr_pc;
    logic [W-1:0] fetch_pc;

    always #5 clk = ~clk;

    pl_fetch_unit_if #(.PROG_CTR_WID(W)) bus ();

    pl_fetch_unit #(.PROG_CTR_WID(W), .BUF_DEPTH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_ID         (stall_ID),
        .branch_taken_EX  (branch_taken_EX),
        .branch_target_EX (branch_target_EX),
        .imem             (bus.master),
        .instr_mem_out    (instr_mem_out),
        .instr_valid      (instr_valid),
        .instr_pc         (instr_pc),
        .fetch_pc         (fetch_pc)
    );

    typedef struct {
        logic         stall;
        logic         req;
        logic [W-1:0] addr;
        logic         valid;
        logic [W-1:0] pc;
    } vec_t;

    typedef struct {
        int           due;
        logic [W-1:0] addr;
    } pend_t;

    vec_t  vecs [19];
    pend_t pend [$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;
    logic spurious;

    logic         s_req, s_valid;
    logic [W-1:0] s_addr, s_pc;
    logic [15:0]  s_out;

    function automatic logic [15:0] mem_word(input logic [W-1:0] a);
        return {6'h2d, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic  resp;
        pend_t p;
        resp = 1'b0;
        if (spurious) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 16'hbeef;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend[0].addr);
            resp = 1'b1;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 16'h0000;
        end
        @(negedge clk);
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_valid = instr_valid;
        s_out   = instr_mem_out;
        s_pc    = instr_pc;
        if (s_req && bus.imem_ready) begin
            p.due  = cyc + lat;
            p.addr = s_addr;
            pend.push_back(p);
        end
        if (resp) void'(pend.pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        stall_ID        = 1'b0;
        branch_taken_EX = 1'b0;
        pend.delete();
        tick();
        tick();
    endtask

    task automatic chk_out(input string tag, input logic valid, input logic [W-1:0] pc);
        chk({tag, "_valid"}, {31'd0, s_valid}, {31'd0, valid});
        chk({tag, "_pc"}, {22'd0, s_pc}, {22'd0, valid ? pc : 10'd0});
        chk({tag, "_out"}, {16'd0, s_out}, {16'd0, valid ? mem_word(pc) : 16'h0000});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n;
        logic seen_req;
        logic [W-1:0] first_addr;

        // Streaming at L=1 with two credits, then a five-cycle stall from row 10.
        vecs[0]  = '{1'b0, 1'b1, 10'd0, 1'b0, 10'd0};
        vecs[1]  = '{1'b0, 1'b1, 10'd1, 1'b0, 10'd0};
        vecs[2]  = '{1'b0, 1'b0, 10'd2, 1'b1, 10'd0};
        vecs[3]  = '{1'b0, 1'b1, 10'd2, 1'b1, 10'd1};
        vecs[4]  = '{1'b0, 1'b1, 10'd3, 1'b0, 10'd0};
        vecs[5]  = '{1'b0, 1'b0, 10'd4, 1'b1, 10'd2};
        vecs[6]  = '{1'b0, 1'b1, 10'd4, 1'b1, 10'd3};
        vecs[7]  = '{1'b0, 1'b1, 10'd5, 1'b0, 10'd0};
        vecs[8]  = '{1'b0, 1'b0, 10'd6, 1'b1, 10'd4};
        vecs[9]  = '{1'b0, 1'b1, 10'd6, 1'b1, 10'd5};
        vecs[10] = '{1'b1, 1'b1, 10'd7, 1'b0, 10'd0};
        vecs[11] = '{1'b1, 1'b0, 10'd8, 1'b1, 10'd6};
        vecs[12] = '{1'b1, 1'b0, 10'd8, 1'b1, 10'd6};
        vecs[13] = '{1'b1, 1'b0, 10'd8, 1'b1, 10'd6};
        vecs[14] = '{1'b1, 1'b0, 10'd8, 1'b1, 10'd6};
        vecs[15] = '{1'b0, 1'b0, 10'd8, 1'b1, 10'd6};
        vecs[16] = '{1'b0, 1'b1, 10'd8, 1'b1, 10'd7};
        vecs[17] = '{1'b0, 1'b1, 10'd9, 1'b0, 10'd0};
        vecs[18] = '{1'b0, 1'b0, 10'd10, 1'b1, 10'd8};

        rst              = 1'b1;
        stall_ID         = 1'b0;
        branch_taken_EX  = 1'b0;
        branch_target_EX = '0;
        bus.imem_ready   = 1'b1;
        bus.imem_rvalid  = 1'b0;
        bus.imem_rdata   = 16'h0000;
        spurious         = 1'b0;

        do_reset();
        chk("rst_req", {31'd0, s_req}, 32'd0);
        chk("rst_addr", {22'd0, s_addr}, 32'd0);
        chk_out("rst", 1'b0, 10'd0);

        // Response with nothing outstanding, memory not ready.
        rst = 1'b0;
        bus.imem_ready = 1'b0;
        spurious = 1'b1;
        tick();
        spurious = 1'b0;
        tick();
        chk("spur_valid", {31'd0, s_valid}, 32'd0);
        chk("spur_req", {31'd0, s_req}, 32'd1);
        chk("spur_addr", {22'd0, s_addr}, 32'd0);
        bus.imem_ready = 1'b1;

        for (int i = 0; i < 19; i++) begin
            stall_ID = vecs[i].stall;
            tick();
            chk($sformatf("vec%0d_req", i), {31'd0, s_req}, {31'd0, vecs[i].req});
            chk($sformatf("vec%0d_addr", i), {22'd0, s_addr}, {22'd0, vecs[i].addr});
            chk_out($sformatf("vec%0d", i), vecs[i].valid, vecs[i].pc);
        end

        // Redirect with two requests in flight at L=3.
        do_reset();
        rst = 1'b0;
        lat = 3;
        tick();
        tick();
        branch_taken_EX  = 1'b1;
        branch_target_EX = 10'h155;
        tick();
        chk("redir_req", {31'd0, s_req}, 32'd0);
        branch_taken_EX = 1'b0;
        tick();
        chk("redir_empty", {31'd0, s_valid}, 32'd0);
        chk("redir_nocredit", {31'd0, s_req}, 32'd0);
        n = 0;
        seen_req = 1'b0;
        first_addr = '0;
        while (n < 20) begin
            tick();
            n++;
            if (s_req && !seen_req) begin
                seen_req   = 1'b1;
                first_addr = s_addr;
            end
            if (s_valid) break;
        end
        chk("redir_first_addr", {22'd0, first_addr}, 32'h155);
        chk("redir_lat", n, 5);
        chk_out("redir_head", 1'b1, 10'h155);
        tick();
        chk_out("redir_next", 1'b1, 10'h156);

        // Redirect coinciding with a response and a stall, target at top of PC space.
        do_reset();
        rst = 1'b0;
        lat = 1;
        tick();
        tick();
        stall_ID         = 1'b1;
        branch_taken_EX  = 1'b1;
        branch_target_EX = 10'h3ff;
        tick();
        chk("coin_req", {31'd0, s_req}, 32'd0);
        stall_ID        = 1'b0;
        branch_taken_EX = 1'b0;
        tick();
        chk_out("coin_t1", 1'b0, 10'd0);
        chk("coin_t1_req", {31'd0, s_req}, 32'd1);
        chk("wrap_addr_hi", {22'd0, s_addr}, 32'h3ff);
        tick();
        chk("wrap_addr_lo", {22'd0, s_addr}, 32'h000);
        chk("wrap_req", {31'd0, s_req}, 32'd1);
        tick();
        chk_out("wrap_head", 1'b1, 10'h3ff);
        tick();
        chk_out("wrap_next", 1'b1, 10'h000);

        // Reset with one word buffered and one request outstanding.
        do_reset();
        rst = 1'b0;
        stall_ID = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        pend.delete();
        tick();
        chk("mrst_req", {31'd0, s_req}, 32'd0);
        rst = 1'b0;
        stall_ID = 1'b0;
        tick();
        chk_out("mrst_out", 1'b0, 10'd0);
        chk("mrst_req1", {31'd0, s_req}, 32'd1);
        chk("mrst_addr0", {22'd0, s_addr}, 32'd0);
        tick();
        chk("mrst_addr1", {22'd0, s_addr}, 32'd1);
        tick();
        chk_out("mrst_head", 1'b1, 10'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
